flex_updown_counter: RTL and testbench
======================================

Name: flex_updown_counter

Overview:
Parametrised up/down counter and successor to the single-direction flex counter.
- Adds a direction control, a parallel load and a wrap/saturate mode select.
- Adds a zero flag alongside the rollover flag.
- Used as the timing and bit-count primitive inside serial receivers, transmitters and timers.
- All outputs are registered.

Parameters:
NUM_CNT_BITS, 4, width of count_out, rollover_val and load_val (minimum 2).

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear to 0; highest priority
load  input  1  synchronous parallel load of load_val
load_val  input  NUM_CNT_BITS  value loaded when load=1
count_enable  input  1  advance count by one step this cycle
count_up  input  1  1 = increment, 0 = decrement
sat_mode  input  1  1 = saturate at the ends, 0 = wrap
rollover_val  input  NUM_CNT_BITS  upper count limit, unsigned
count_out  output  NUM_CNT_BITS  current count
rollover_flag  output  1  count_out equals rollover_val
zero_flag  output  1  count_out reached 0 by down-counting

Behaviour:
- Clock and reset: one clock domain (clk). n_rst is asynchronous and active-low; reset polarity and synchronicity are fixed.
- Reset: count_out=0, rollover_flag=0, zero_flag=0, applied immediately on n_rst falling. A reset mid-count discards the state.
- Priority per rising edge: clear > load > count_enable > hold.
- clear: next count=0. Both flags=0 the following cycle.
- load: next count=load_val. rollover_flag=(load_val==rollover_val). zero_flag=0.
- Up step (count_enable=1, count_up=1), let C = count_out, R = rollover_val:
  - C<R: C+1.
  - C>=R, wrap mode: next = 1.
  - C>=R, saturate mode: next = R (clamps an out-of-range load down to R).
- Down step (count_enable=1, count_up=0):
  - C>R: C-1.
  - 0<C<=R: C-1.
  - C==0, wrap mode: next = R.
  - C==0, saturate mode: hold 0.
- rollover_val==0: up steps hold the count (no change, no flags). Down steps follow the rules above.
- Flags are registered with the count, so there is zero added latency relative to count_out:
  - rollover_flag = 1 iff next count == R and R != 0, evaluated on every update (step, load, hold).
  - zero_flag = 1 iff the update was a down step producing 0. A hold keeps the previous zero_flag. Any other update clears it.
- rollover_val may change at any time. The new value takes effect on the next edge; a count above the new R follows the C>=R / C>R rules.
- Arithmetic is unsigned, NUM_CNT_BITS wide, with no internal overflow. When R = all-ones, C+1 is never computed from all-ones.

Optional Feature:
FLEX_CNT_PRESCALE_EN
- Defined: adds parameter PRESCALE_BITS (default 4) and input prescale_val [PRESCALE_BITS].
  - A step occurs only on every (prescale_val+1)-th cycle with count_enable=1; the prescaler holds while count_enable=0.
  - clear, load and reset zero the prescaler.
  - prescale_val=0 behaves as undefined-macro.
- Undefined: every enabled cycle steps; no extra port or parameter.

Decomposition:
- Package flex_cnt_pkg:
  - enum cnt_dir_t {CNT_DOWN=0, CNT_UP=1};
  - enum cnt_mode_t {CNT_WRAP=0, CNT_SAT=1};
  - localparam DEFAULT_CNT_BITS=4.
- Sub-module flex_prescaler: enable divider, instantiated only under FLEX_CNT_PRESCALE_EN.
- Next-state logic stays in one combinational block inside flex_updown_counter.

Test Plan:
1. Reset mid-count: NUM_CNT_BITS=4, count to 5, assert n_rst=0 between edges -> count_out=0 and both flags=0 immediately; still 0 after two edges.
2. Up wrap, R=5: seven enabled cycles from 0 -> 1,2,3,4,5,1,2; rollover_flag=1 only while count_out=5.
3. Down wrap and saturate, R=3, load 2:
   - Wrap mode -> 1,0,3,2; zero_flag=1 only at the first 0.
   - Repeat in saturate mode -> 1,0,0,0; zero_flag stays 1 while held.
4. Priority: clear=1, load=1, load_val=7, count_enable=1 same edge -> count_out=0. Next edge with load only -> 7.
5. Out-of-range load, R=4, load 9:
   - Up wrap -> 1.
   - Up saturate -> 4 with rollover_flag=1.
   - Down -> 8.
6. R=15 (all-ones): up from 14 -> 15 with rollover_flag=1, then 1 (wrap), with no X or overflow.

Source files
------------

// File: rtl/flex_cnt_pkg.sv
// Shared types and defaults for the flex up/down counter family.
// Direction and mode encodings match the raw count_up / sat_mode input bits.
package flex_cnt_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;

  localparam int DEFAULT_CNT_BITS = 4;

endpackage

// File: rtl/flex_prescaler.sv
// Enable divider: o_tick fires on every (i_prescale_val+1)-th enabled cycle.
// Only built into flex_updown_counter when FLEX_CNT_PRESCALE_EN is defined.
module flex_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_sync_clr,
  input  logic                     i_enable,
  input  logic [PRESCALE_BITS-1:0] i_prescale_val,
  output logic                     o_tick
);

  logic [PRESCALE_BITS-1:0] r_div;
  logic                     w_terminal;

  assign w_terminal = (r_div == i_prescale_val);
  assign o_tick     = i_enable && w_terminal;

  // Holds while disabled so partial periods survive gaps in count_enable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div <= '0;
    end else if (i_sync_clr) begin
      r_div <= '0;
    end else if (i_enable) begin
      if (w_terminal) r_div <= '0;
      else            r_div <= r_div + PRESCALE_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate mode and registered flags.
// Optional enable prescaler is built in when FLEX_CNT_PRESCALE_EN is defined.
module flex_updown_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
`ifdef FLEX_CNT_PRESCALE_EN
  ,
  parameter int PRESCALE_BITS = 4
`endif
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
`ifdef FLEX_CNT_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    zero_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_cnt;
  logic                    r_roll;
  logic                    r_zero;

  logic [NUM_CNT_BITS-1:0] w_next;
  logic                    w_roll_next;
  logic                    w_zero_next;
  logic                    w_step;
  cnt_dir_t                w_dir;
  cnt_mode_t               w_mode;

  assign w_dir  = cnt_dir_t'(count_up);
  assign w_mode = cnt_mode_t'(sat_mode);

`ifdef FLEX_CNT_PRESCALE_EN
  flex_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_sync_clr     (clear | load),
    .i_enable       (count_enable),
    .i_prescale_val (prescale_val),
    .o_tick         (w_step)
  );
`else
  assign w_step = count_enable;
`endif

  // C+1 is only formed when C < R, so it can never overflow even with R all-ones.
  always_comb begin
    w_next      = r_cnt;
    w_zero_next = r_zero;
    if (clear) begin
      w_next      = '0;
      w_zero_next = 1'b0;
    end else if (load) begin
      w_next      = load_val;
      w_zero_next = 1'b0;
    end else if (w_step) begin
      if (w_dir == CNT_UP) begin
        w_zero_next = 1'b0;
        if (rollover_val == '0)      w_next = r_cnt;
        else if (r_cnt < rollover_val) w_next = r_cnt + ONE;
        else if (w_mode == CNT_SAT)  w_next = rollover_val;
        else                         w_next = ONE;
      end else begin
        if (r_cnt != '0)             w_next = r_cnt - ONE;
        else if (w_mode == CNT_SAT)  w_next = '0;
        else                         w_next = rollover_val;
        w_zero_next = (w_next == '0);
      end
    end
    w_roll_next = (w_next == rollover_val) && (rollover_val != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_roll <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_cnt  <= w_next;
      r_roll <= w_roll_next;
      r_zero <= w_zero_next;
    end
  end

  assign count_out     = r_cnt;
  assign rollover_flag = r_roll;
  assign zero_flag     = r_zero;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed self-checking bench for flex_updown_counter (NUM_CNT_BITS=4).
module tb_flex_updown_counter;

  localparam int W = 4;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         count_enable;
  logic         count_up;
  logic         sat_mode;
  logic [W-1:0] rollover_val;
`ifdef FLEX_CNT_PRESCALE_EN
  logic [3:0]   prescale_val;
`endif
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         zero_flag;

  int n_checks;
  int n_fail;

  flex_updown_counter #(.NUM_CNT_BITS(W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .load          (load),
    .load_val      (load_val),
    .count_enable  (count_enable),
    .count_up      (count_up),
    .sat_mode      (sat_mode),
    .rollover_val  (rollover_val),
`ifdef FLEX_CNT_PRESCALE_EN
    .prescale_val  (prescale_val),
`endif
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .zero_flag     (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    clear        = 1'b0;
    load         = 1'b0;
    count_enable = 1'b0;
  endtask

  // One edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; count_enable = 1'b0; clear = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: got cnt=%0d rf=%b zf=%b want 0/0/0", count_out, rollover_flag, zero_flag);
    end
    tick();
    n_rst = 1'b1;
    rollover_val = 4'd10; count_up = 1'b1; count_enable = 1'b1;
    repeat (5) tick();
    count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_precount: got %0d want 5", count_out);
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got cnt=%0d rf=%b zf=%b want 0/0/0", count_out, rollover_flag, zero_flag);
    end
    count_enable = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got cnt=%0d rf=%b zf=%b want 0/0/0", count_out, rollover_flag, zero_flag);
    end
    count_enable = 1'b0;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp_cnt [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
    rollover_val = 4'd5; sat_mode = 1'b0; count_up = 1'b1;
    clear = 1'b1; tick(); clear = 1'b0;
    count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (count_out !== exp_cnt[i] || rollover_flag !== (exp_cnt[i] == 4'd5) || zero_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got cnt=%0d rf=%b zf=%b want %0d/%b/0", i, count_out, rollover_flag,
                 zero_flag, exp_cnt[i], (exp_cnt[i] == 4'd5));
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_down_modes();
    logic [W-1:0] exp_w [4] = '{4'd1, 4'd0, 4'd3, 4'd2};
    logic         zf_w  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] exp_s [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic         zf_s  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    rollover_val = 4'd3; count_up = 1'b0; sat_mode = 1'b0;
    do_load(4'd2);
    count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count_out !== exp_w[i] || zero_flag !== zf_w[i] || rollover_flag !== (exp_w[i] == 4'd3)) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: got cnt=%0d zf=%b rf=%b want %0d/%b/%b", i, count_out, zero_flag,
                 rollover_flag, exp_w[i], zf_w[i], (exp_w[i] == 4'd3));
      end
    end
    sat_mode = 1'b1;
    do_load(4'd2);
    count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count_out !== exp_s[i] || zero_flag !== zf_s[i] || rollover_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL down_sat[%0d]: got cnt=%0d zf=%b rf=%b want %0d/%b/0", i, count_out, zero_flag,
                 rollover_flag, exp_s[i], zf_s[i]);
      end
    end
    // A disabled cycle is a hold: zero_flag must persist.
    count_enable = 1'b0;
    tick();
    n_checks++;
    if (count_out !== 4'd0 || zero_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_zero: got cnt=%0d zf=%b want 0/1", count_out, zero_flag);
    end
    sat_mode = 1'b0;
  endtask

  task automatic test_priority();
    rollover_val = 4'd3; count_up = 1'b1;
    do_load(4'd3);
    clear = 1'b1; load = 1'b1; load_val = 4'd7; count_enable = 1'b1;
    tick();
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_clear: got cnt=%0d rf=%b zf=%b want 0/0/0", count_out, rollover_flag, zero_flag);
    end
    clear = 1'b0; count_enable = 1'b0;
    tick();
    load = 1'b0;
    n_checks++;
    if (count_out !== 4'd7 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load: got cnt=%0d rf=%b want 7/0", count_out, rollover_flag);
    end
  endtask

  task automatic test_out_of_range();
    rollover_val = 4'd4;
    do_load(4'd9);
    n_checks++;
    if (count_out !== 4'd9 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_load: got cnt=%0d rf=%b want 9/0", count_out, rollover_flag);
    end
    count_up = 1'b1; sat_mode = 1'b0; count_enable = 1'b1;
    tick(); count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd1 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_up_wrap: got cnt=%0d rf=%b want 1/0", count_out, rollover_flag);
    end
    do_load(4'd9);
    sat_mode = 1'b1; count_enable = 1'b1;
    tick(); count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd4 || rollover_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_up_sat: got cnt=%0d rf=%b want 4/1", count_out, rollover_flag);
    end
    do_load(4'd9);
    count_up = 1'b0; count_enable = 1'b1;
    tick(); count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd8 || zero_flag !== 1'b0 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_down: got cnt=%0d zf=%b rf=%b want 8/0/0", count_out, zero_flag, rollover_flag);
    end
    sat_mode = 1'b0;
  endtask

  task automatic test_all_ones();
    rollover_val = 4'd15; count_up = 1'b1; sat_mode = 1'b0;
    do_load(4'd14);
    count_enable = 1'b1;
    tick();
    n_checks++;
    if (count_out !== 4'd15 || rollover_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_top: got cnt=%0d rf=%b want 15/1", count_out, rollover_flag);
    end
    tick();
    count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd1 || rollover_flag !== 1'b0 || $isunknown(count_out)) begin
      n_fail++;
      $display("FAIL ones_wrap: got cnt=%0d rf=%b want 1/0", count_out, rollover_flag);
    end
  endtask

  task automatic test_zero_limit();
    rollover_val = 4'd0; count_up = 1'b1;
    do_load(4'd6);
    count_enable = 1'b1;
    tick();
    n_checks++;
    if (count_out !== 4'd6 || rollover_flag !== 1'b0 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_up_hold: got cnt=%0d rf=%b zf=%b want 6/0/0", count_out, rollover_flag, zero_flag);
    end
    count_up = 1'b0;
    tick();
    count_enable = 1'b0;
    n_checks++;
    if (count_out !== 4'd5 || rollover_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_down: got cnt=%0d rf=%b want 5/0", count_out, rollover_flag);
    end
    // Raising R to the held count makes rollover_flag assert on a plain hold.
    rollover_val = 4'd5;
    tick();
    n_checks++;
    if (count_out !== 4'd5 || rollover_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL rchange_hold: got cnt=%0d rf=%b want 5/1", count_out, rollover_flag);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst = 1'b0;
    idle_inputs();
    load_val = '0; count_up = 1'b1; sat_mode = 1'b0; rollover_val = '0;
`ifdef FLEX_CNT_PRESCALE_EN
    prescale_val = '0;
`endif
    test_reset();
    test_up_wrap();
    test_down_modes();
    test_priority();
    test_out_of_range();
    test_all_ones();
    test_zero_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
